sha256_compress_iter: RTL
=========================

// Module: sha256_compress_iter
// PURPOSE
//  Iterative SHA-256 compression engine for one 512-bit message block.
//  Built on the single-round datapath (T1/T2, Sigma0/1, Ch, Maj); instantiates ROUNDS_PER_CYCLE
//  chained rounds, an on-chip 64-entry K ROM and a rolling 16-word message schedule.
//  Sits between the padding/block feeder and the digest sink; multi-block messages chain via hash_i.
// PARAMETERS
//  ROUNDS_PER_CYCLE  1   rounds unrolled per clock; legal 1,2,4,8,16 (must divide 64)
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst        in   1    asynchronous, active-high reset
//  start_i    in   1    request: compress block_i with chaining value selected by use_iv_i
//  ready_o    out  1    engine idle, start_i will be accepted this cycle
//  use_iv_i   in   1    1: chain = FIPS 180-4 IV (6a09e667..5be0cd19); 0: chain = hash_i
//  block_i    in   512  message block; [511:480]=W0 ... [31:0]=W15 (big-endian words)
//  hash_i     in   256  chaining value; [255:224]=H0(a) ... [31:0]=H7(h)
//  digest_o   out  256  result H0..H7, same packing as hash_i
//  done_o     out  1    one-cycle pulse: digest_o updated
// BEHAVIOUR
//  Reset: ready_o=1, done_o=0, digest_o=0, FSM=IDLE, round counter=0; applies asynchronously at any time,
//   including mid-compression (partial work discarded, no done_o pulse).
//  Handshake: start accepted on rising edge where start_i&&ready_o. block_i, hash_i, use_iv_i sampled
//   on that edge only; may change afterwards. start_i while ready_o=0 ignored (not queued).
//  FSM: IDLE -(accept)-> ROUND -(counter reaches 64)-> FINAL -> IDLE.
//   IDLE : ready_o=1. On accept: a..h <= chain; H-save <= chain; W window <= block_i; t <= 0.
//   ROUND: ready_o=0. Each clock applies R=ROUNDS_PER_CYCLE rounds t..t+R-1 combinationally chained;
//          t <= t+R. Leaves to FINAL on the edge where t+R==64 (counter 7-bit, no wrap inside ROUND).
//   FINAL: ready_o=0. digest_o <= {H0+a,...,H7+h} (each mod 2^32); done_o=1 next cycle; -> IDLE.
//  Latency: done_o high in cycle 64/R+1 after the accept edge (R=1: 65 clocks, R=4: 17, R=16: 5).
//   Throughput one block per 64/R+2 clocks (ready_o high one cycle between blocks).
//  Back-to-back: start_i may be asserted in the same cycle done_o is high (engine is IDLE then);
//   hash_i may be tied to digest_o for chaining — digest_o is already valid in that cycle.
//  Round function per round j: T1=h+Sigma1(e)+Ch(e,f,g)+K[j]+W[j]; T2=Sigma0(a)+Maj(a,b,c);
//   a<=T1+T2, e<=d+T1, b,c,d<=a,b,c, f,g,h<=e,f,g. All adds mod 2^32, carries dropped.
//   Sigma0=ROTR2^ROTR13^ROTR22, Sigma1=ROTR6^ROTR11^ROTR25.
//  Schedule: 16-word window; W[j]=block word for j<16, else sigma1(W[j-2])+W[j-7]+sigma0(W[j-15])+W[j-16];
//   sigma0=ROTR7^ROTR18^SHR3, sigma1=ROTR17^ROTR19^SHR10. Window shifts by R words per clock;
//   words produced within one clock feed later rounds of that clock.
//  K ROM: 64x32 constants from FIPS 180-4, indexed by t+j (j<R); combinational lookup.
//  digest_o holds its value until the next FINAL or reset; never glitches during ROUND.
// TESTING
//  T1 "abc": block_i=61626380_0..0_00000018, use_iv_i=1, R=1 -> done_o 65 clocks after accept,
//     digest_o=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  T2 empty msg: block_i=80000000_0..0_00000000, use_iv_i=1 -> digest_o=e3b0c44298fc1c149afbf4c8
//     996fb92427ae41e4649b934ca495991b7852b855.
//  T3 two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with use_iv_i=1,
//     block 2 with use_iv_i=0, hash_i=digest_o, start_i in done_o cycle -> digest_o=248d6a61d20638b8
//     e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; gap between done pulses = 66 clocks (R=1).
//  T4 parameter sweep R=1,2,4,8,16 rerunning T1..T3 -> identical digests, latency 64/R+1.
//  T5 start_i held high during ROUND and block_i/hash_i toggled randomly -> ignored, digest per T1.
//  T6 rst pulsed at round 30 of T1 -> ready_o=1, digest_o=0, no done_o; following T1 run correct.

Source files
------------

// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression of one 512-bit block.
// Each clock applies ROUNDS_PER_CYCLE chained rounds over a rolling 16-word schedule window.
module sha256_compress_iter #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    output logic         ready_o,
    input  logic         use_iv_i,
    input  logic [511:0] block_i,
    input  logic [255:0] hash_i,
    output logic [255:0] digest_o,
    output logic         done_o
);

    localparam int unsigned R    = ROUNDS_PER_CYCLE;
    localparam int unsigned NW   = 16;
    localparam logic [6:0]  STEP = 7'(R);
    localparam logic [6:0]  LAST = 7'd64;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t           state;
    logic [6:0]       t;
    logic [7:0][31:0] hv;          // [7]=a ... [0]=h
    logic [7:0][31:0] hsave;
    logic [15:0][31:0] win;        // [15]=W[t] ... [0]=W[t+15]
    logic [7:0][31:0] hv_next;
    logic [15:0][31:0] win_next;
    logic [7:0][31:0] sum;
    logic [255:0]     chain;
    logic [31:0]      ext [NW+R];
    logic [7:0][31:0] rs [R+1];
    logic [31:0]      t1 [R];
    logic [31:0]      t2 [R];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign chain = use_iv_i ? IV : hash_i;

    // Schedule extension and R chained rounds; new words feed later rounds of the same clock.
    always_comb begin
        for (int k = 0; k < 16; k++) ext[k] = win[15-k];
        for (int k = 0; k < int'(R); k++)
            ext[16+k] = ssig1(ext[14+k]) + ext[9+k] + ssig0(ext[1+k]) + ext[k];
        rs[0] = hv;
        for (int j = 0; j < int'(R); j++) begin
            t1[j] = rs[j][0] + bsig1(rs[j][3]) + ((rs[j][3] & rs[j][2]) ^ (~rs[j][3] & rs[j][1]))
                  + K[6'(t + 7'(j))] + ext[j];
            t2[j] = bsig0(rs[j][7])
                  + ((rs[j][7] & rs[j][6]) ^ (rs[j][7] & rs[j][5]) ^ (rs[j][6] & rs[j][5]));
            rs[j+1] = {t1[j] + t2[j], rs[j][7:5], rs[j][4] + t1[j], rs[j][3:1]};
        end
        for (int k = 0; k < 16; k++) win_next[15-k] = ext[int'(R)+k];
        hv_next = rs[R];
        for (int i = 0; i < 8; i++) sum[i] = hsave[i] + hv[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            t        <= 7'd0;
            hv       <= '0;
            hsave    <= '0;
            win      <= '0;
            ready_o  <= 1'b1;
            done_o   <= 1'b0;
            digest_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && ready_o) begin
                        hv      <= chain;
                        hsave   <= chain;
                        win     <= block_i;
                        t       <= 7'd0;
                        ready_o <= 1'b0;
                        state   <= ROUND;
                    end
                end
                ROUND: begin
                    hv  <= hv_next;
                    win <= win_next;
                    t   <= t + STEP;
                    if (t + STEP == LAST) state <= FINAL;
                end
                FINAL: begin
                    digest_o <= sum;
                    done_o   <= 1'b1;
                    ready_o  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
